// File: rtl/int_source_ctrl_if.sv
// Signal bundle between the interrupt front end and its software/core side.
// The master drives requests and control strobes; the slave is int_source_ctrl.
interface int_source_ctrl_if #(
    parameter int N_SRC = 8
);
    localparam int IDW = $clog2(N_SRC);

    logic [N_SRC-1:0] irq_in;
    logic             mask_we;
    logic [N_SRC-1:0] mask_wdata;
    logic             clr_we;
    logic [N_SRC-1:0] clr_wdata;
    logic             eret;
    logic             int_out;
    logic [IDW-1:0]   cause_id;
    logic             cause_valid;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;

    modport master (
        output irq_in, mask_we, mask_wdata, clr_we, clr_wdata, eret,
        input  int_out, cause_id, cause_valid, pending, mask
    );

    modport slave (
        input  irq_in, mask_we, mask_wdata, clr_we, clr_wdata, eret,
        output int_out, cause_id, cause_valid, pending, mask
    );
endinterface

// File: rtl/int_source_ctrl.sv
// Multi-source interrupt front end: synchronizes request lines, latches rising edges,
// masks and arbitrates by fixed priority, and drives one registered INT pulse per grant.
module int_source_ctrl #(
    parameter int N_SRC   = 8,
    parameter int PULSE_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    int_source_ctrl_if.slave bus
);
    localparam int IDW = $clog2(N_SRC);
    localparam int CW  = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Lowest set index wins; bit 0 has the highest priority.
    function automatic logic [IDW-1:0] lowest_index(input logic [N_SRC-1:0] vec);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDW'(i);
            end
        end
        return idx;
    endfunction

    logic [N_SRC-1:0] r_s1;
    logic [N_SRC-1:0] r_s2;
    logic [N_SRC-1:0] r_s3;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_mask;
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_int_out;
    logic [IDW-1:0]   r_cause_id;
    logic             r_cause_valid;

    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] w_eligible;
    logic             w_grant;
    logic [IDW-1:0]   w_winner;
    logic [N_SRC-1:0] w_grant_vec;
    logic [N_SRC-1:0] w_clr_vec;

    always_comb begin
        w_edge      = r_s2 & ~r_s3;
        w_eligible  = r_pending & ~r_mask;
        w_grant     = (r_state == ST_IDLE) && (w_eligible != '0);
        w_winner    = lowest_index(w_eligible);
        w_grant_vec = '0;
        if (w_grant) begin
            w_grant_vec[w_winner] = 1'b1;
        end else begin
            w_grant_vec = '0;
        end
        if (bus.clr_we) begin
            w_clr_vec = bus.clr_wdata;
        end else begin
            w_clr_vec = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= bus.irq_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // A fresh edge outranks both the grant clear and the software clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_vec & ~w_grant_vec) | w_edge;
            if (bus.mask_we) begin
                r_mask <= bus.mask_wdata;
            end else begin
                r_mask <= r_mask;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_int_out     <= 1'b0;
            r_cause_id    <= '0;
            r_cause_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_grant) begin
                        r_state       <= ST_ASSERT;
                        r_cause_id    <= w_winner;
                        r_int_out     <= 1'b1;
                        r_cause_valid <= 1'b1;
                    end else begin
                        r_int_out     <= 1'b0;
                        r_cause_valid <= 1'b0;
                    end
                end
                // eret is deliberately not looked at until the pulse has finished.
                ST_ASSERT: begin
                    if (r_cnt == CW'(PULSE_W - 1)) begin
                        r_state   <= ST_SERVICE;
                        r_int_out <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_SERVICE: begin
                    if (bus.eret) begin
                        r_state       <= ST_IDLE;
                        r_cause_valid <= 1'b0;
                    end else begin
                        r_state <= ST_SERVICE;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_cnt         <= '0;
                    r_int_out     <= 1'b0;
                    r_cause_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.int_out     = r_int_out;
    assign bus.cause_id    = r_cause_id;
    assign bus.cause_valid = r_cause_valid;
    assign bus.pending     = r_pending;
    assign bus.mask        = r_mask;
endmodule

// File: tb/tb_int_source_ctrl.sv
// Bench for int_source_ctrl: directed scenarios then random traffic, all checked
// cycle by cycle against a delay-line/countdown reference model.
module tb_int_source_ctrl;
    localparam int N_SRC   = 8;
    localparam int PULSE_W = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int_source_ctrl_if #(.N_SRC(N_SRC)) bus ();

    int_source_ctrl #(.N_SRC(N_SRC), .PULSE_W(PULSE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: raw samples of irq_in, pending/mask, and service bookkeeping.
    logic [7:0] m_samp [3];
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    bit         m_busy;
    int         m_pulse_left;
    logic [2:0] m_cause;
    logic [7:0] cur_irq;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_samp[i] = 8'h00;
        m_pend       = 8'h00;
        m_mask       = 8'h00;
        m_busy       = 1'b0;
        m_pulse_left = 0;
        m_cause      = 3'd0;
    endtask

    // Effect of one rising clock edge given the inputs present before it.
    task automatic model_edge(input logic [7:0] irq, input logic mwe, input logic [7:0] mwd,
                              input logic cwe, input logic [7:0] cwd, input logic er);
        logic [7:0] edge_v;
        logic [7:0] elig;
        logic [7:0] gbit;
        logic [7:0] one;
        edge_v = m_samp[1] & ~m_samp[2];
        elig   = m_pend & ~m_mask;
        gbit   = 8'h00;
        one    = 8'h01;
        if (!m_busy) begin
            if (elig != 8'h00) begin
                for (int i = N_SRC - 1; i >= 0; i--) if (elig[i]) m_cause = 3'(i);
                gbit         = one << m_cause;
                m_busy       = 1'b1;
                m_pulse_left = PULSE_W;
            end
        end else if (m_pulse_left > 0) begin
            m_pulse_left--;
        end else if (er) begin
            m_busy = 1'b0;
        end
        m_pend = (m_pend & ~(cwe ? cwd : 8'h00) & ~gbit) | edge_v;
        if (mwe) m_mask = mwd;
        m_samp[2] = m_samp[1];
        m_samp[1] = m_samp[0];
        m_samp[0] = irq;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".int_out"},     32'(bus.int_out),     32'(m_pulse_left > 0));
        check_eq({tag, ".cause_valid"}, 32'(bus.cause_valid), 32'(m_busy));
        check_eq({tag, ".cause_id"},    32'(bus.cause_id),    32'(m_cause));
        check_eq({tag, ".pending"},     32'(bus.pending),     32'(m_pend));
        check_eq({tag, ".mask"},        32'(bus.mask),        32'(m_mask));
    endtask

    task automatic step(input logic [7:0] irq, input logic mwe, input logic [7:0] mwd,
                        input logic cwe, input logic [7:0] cwd, input logic er);
        @(negedge clk);
        bus.irq_in     = irq;
        bus.mask_we    = mwe;
        bus.mask_wdata = mwd;
        bus.clr_we     = cwe;
        bus.clr_wdata  = cwd;
        bus.eret       = er;
        cur_irq        = irq;
        model_edge(irq, mwe, mwd, cwe, cwd, er);
        @(posedge clk);
        #1;
        compare_all("cyc");
    endtask

    task automatic tick(input logic [7:0] irq, input logic er);
        step(irq, 1'b0, 8'h00, 1'b0, 8'h00, er);
    endtask

    initial begin
        int   rises;
        logic prev;
        reset          = 1'b1;
        bus.irq_in     = 8'h00;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = 8'h00;
        bus.clr_we     = 1'b0;
        bus.clr_wdata  = 8'h00;
        bus.eret       = 1'b0;
        cur_irq        = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single source on bit 5
        for (int i = 0; i < 3; i++) tick(8'h20, 1'b0);
        check_eq("single_quiet", 32'(bus.int_out), 32'd0);
        tick(8'h20, 1'b0);
        check_eq("single_int", 32'(bus.int_out), 32'd1);
        check_eq("single_id", 32'(bus.cause_id), 32'd5);
        check_eq("single_pend", 32'(bus.pending), 32'h00);
        tick(8'h20, 1'b0);
        check_eq("single_int2", 32'(bus.int_out), 32'd1);
        tick(8'h20, 1'b0);
        check_eq("single_low", 32'(bus.int_out), 32'd0);
        check_eq("single_svc", 32'(bus.cause_valid), 32'd1);
        tick(8'h00, 1'b1);
        check_eq("single_eret", 32'(bus.cause_valid), 32'd0);

        // Priority between bits 1 and 6
        for (int i = 0; i < 4; i++) tick(8'h42, 1'b0);
        check_eq("prio_id1", 32'(bus.cause_id), 32'd1);
        check_eq("prio_pend", 32'(bus.pending), 32'h40);
        tick(8'h42, 1'b0);
        tick(8'h42, 1'b0);
        tick(8'h42, 1'b1);
        check_eq("prio_idle", 32'(bus.cause_valid), 32'd0);
        tick(8'h42, 1'b0);
        check_eq("prio_int6", 32'(bus.int_out), 32'd1);
        check_eq("prio_id6", 32'(bus.cause_id), 32'd6);
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b1);

        // Masked source serviced once unmasked
        step(8'h00, 1'b1, 8'h04, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) tick(8'h04, 1'b0);
        check_eq("mask_pend", 32'(bus.pending), 32'h04);
        check_eq("mask_noint", 32'(bus.int_out), 32'd0);
        step(8'h04, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("mask_wr_noint", 32'(bus.int_out), 32'd0);
        tick(8'h04, 1'b0);
        check_eq("mask_grant", 32'(bus.int_out), 32'd1);
        check_eq("mask_id", 32'(bus.cause_id), 32'd2);
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b1);

        // Held level gives one grant; re-raise during service is remembered
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(8'h01, 1'b0);
            if (bus.int_out && !prev) rises++;
            prev = bus.int_out;
        end
        check_eq("held_rises", 32'(rises), 32'd1);
        for (int i = 0; i < 3; i++) tick(8'h00, 1'b0);
        for (int i = 0; i < 4; i++) tick(8'h01, 1'b0);
        check_eq("retrig_pend0", 32'(bus.pending[0]), 32'd1);
        check_eq("retrig_svc", 32'(bus.cause_valid), 32'd1);
        tick(8'h01, 1'b1);
        tick(8'h01, 1'b0);
        check_eq("retrig_grant", 32'(bus.int_out), 32'd1);
        check_eq("retrig_id", 32'(bus.cause_id), 32'd0);

        // Clear/set race on bit 3, then eret ignored during ASSERT
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
        tick(8'h08, 1'b0);
        tick(8'h08, 1'b0);
        step(8'h08, 1'b0, 8'h00, 1'b1, 8'h08, 1'b0);
        check_eq("race_pend3", 32'(bus.pending[3]), 32'd1);
        tick(8'h08, 1'b1);
        tick(8'h08, 1'b0);
        check_eq("race_grant", 32'(bus.int_out), 32'd1);
        check_eq("race_id", 32'(bus.cause_id), 32'd3);
        tick(8'h08, 1'b1);
        check_eq("eret_asrt_int", 32'(bus.int_out), 32'd1);
        check_eq("eret_asrt_cv", 32'(bus.cause_valid), 32'd1);
        tick(8'h08, 1'b1);
        check_eq("eret_asrt_svc_int", 32'(bus.int_out), 32'd0);
        check_eq("eret_asrt_svc_cv", 32'(bus.cause_valid), 32'd1);
        tick(8'h08, 1'b1);
        check_eq("eret_svc_idle", 32'(bus.cause_valid), 32'd0);

        // Asynchronous reset in the middle of an ASSERT on source 3
        step(8'h08, 1'b1, 8'h80, 1'b0, 8'h00, 1'b0);
        tick(8'h00, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick(8'h08, 1'b0);
            if (bus.int_out) break;
        end
        check_eq("rst_arm_int", 32'(bus.int_out), 32'd1);
        check_eq("rst_arm_id", 32'(bus.cause_id), 32'd3);
        #2;
        reset      = 1'b1;
        bus.irq_in = 8'h00;
        cur_irq    = 8'h00;
        #1;
        check_eq("rst_int", 32'(bus.int_out), 32'd0);
        check_eq("rst_cv", 32'(bus.cause_valid), 32'd0);
        check_eq("rst_id", 32'(bus.cause_id), 32'd0);
        check_eq("rst_pend", 32'(bus.pending), 32'h00);
        check_eq("rst_mask", 32'(bus.mask), 32'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        #1;
        compare_all("rst_rel");

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] flips;
            logic       mwe;
            logic       cwe;
            flips = 8'h00;
            for (int b = 0; b < N_SRC; b++) flips[b] = ($urandom_range(0, 7) == 0);
            mwe = ($urandom_range(0, 31) == 0);
            cwe = ($urandom_range(0, 15) == 0);
            step(cur_irq ^ flips, mwe, 8'($urandom & $urandom), cwe, 8'($urandom),
                 ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
